uart_tx_fifo: RTL and testbench

Byte FIFO between s3g_tx and uart_transceiver on the transmit path.
- Upstream side presents the same tx_data/tx_wr/tx_done handshake that s3g_tx already drives, so s3g_tx connects unchanged.
- Downstream side drives uart_transceiver tx_data/tx_wr and paces on its tx_done.
- Decouples reply-packet generation from UART bit timing. s3g_tx can dump a whole reply at clock rate until the FIFO fills.

---
 rtl/uart_tx_fifo.sv | 127 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO decoupling s3g_tx reply generation from uart_transceiver bit timing.
// A one-byte hold register absorbs a single write that arrives while the RAM is full.
module uart_tx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            in_data,
    input  logic                  in_wr,
    output logic                  in_done,
    output logic [7:0]            tx_data,
    output logic                  tx_wr,
    input  logic                  tx_done,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    input  logic                  ovf_clr
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2:0] ptr_t;
    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    logic [7:0] mem [DEPTH];
    ptr_t       wr_ptr;
    ptr_t       rd_ptr;
    ptr_t       wr_ptr_nxt;
    ptr_t       rd_ptr_nxt;
    ptr_t       level_nxt;
    logic [7:0] hold;
    logic       pending;
    state_t     state;

    logic       wr_direct;
    logic       wr_capture;
    logic       wr_commit;
    logic       wr_drop;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic       rd_en;

    // Write decisions use the pre-edge (registered) full flag.
    always_comb begin
        wr_direct  = in_wr && !full && !pending;
        wr_capture = in_wr && full && !pending;
        wr_commit  = pending && !full;
        wr_drop    = in_wr && pending;
        ram_we     = wr_direct || wr_commit;
        ram_wdata  = pending ? hold : in_data;
        rd_en      = (state == ST_IDLE) && !empty;
        wr_ptr_nxt = wr_ptr + ptr_t'(ram_we);
        rd_ptr_nxt = rd_ptr + ptr_t'(rd_en);
        level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= ram_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            in_done  <= 1'b0;
            hold     <= '0;
            pending  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            level   <= level_nxt;
            full    <= (level_nxt == ptr_t'(DEPTH));
            empty   <= (level_nxt == '0);
            in_done <= ram_we;
            if (wr_capture) begin
                hold    <= in_data;
                pending <= 1'b1;
            end else if (wr_commit) begin
                pending <= 1'b0;
            end
            // A same-cycle drop outranks the clear.
            if (wr_drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            tx_wr   <= 1'b0;
            tx_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        tx_data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
                        tx_wr   <= 1'b1;
                        state   <= ST_WAIT;
                    end else begin
                        tx_wr   <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    tx_wr <= 1'b0;
                    if (tx_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    tx_wr <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised scoreboard bench for uart_tx_fifo: instance 0 has 16 entries, instance 1 has 4.
// The reference model is the ordered list of accepted bytes; a UART model paces tx_done.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n    [2];
    logic [7:0] in_data  [2];
    logic       in_wr    [2];
    logic       in_done  [2];
    logic [7:0] tx_data  [2];
    logic       tx_wr    [2];
    logic [8:0] level    [2];
    logic       full     [2];
    logic       empty    [2];
    logic       overflow [2];
    logic       ovf_clr  [2];

    logic        withhold   [2];
    logic        rand_delay [2];
    int unsigned uart_delay [2];

    int          checks = 0;
    int          errors = 0;
    int unsigned done_cnt  [2];
    int unsigned txwr_cnt  [2];
    int unsigned accepted  [2];
    int unsigned max_level [2];

    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int unsigned DL = (g == 0) ? 4 : 2;
        logic [DL:0] lvl;
        logic        done_l;

        uart_tx_fifo #(.DEPTH_LOG2(DL)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n[g]),
            .in_data  (in_data[g]),
            .in_wr    (in_wr[g]),
            .in_done  (in_done[g]),
            .tx_data  (tx_data[g]),
            .tx_wr    (tx_wr[g]),
            .tx_done  (done_l),
            .level    (lvl),
            .full     (full[g]),
            .empty    (empty[g]),
            .overflow (overflow[g]),
            .ovf_clr  (ovf_clr[g])
        );
        assign level[g] = 9'(lvl);

        // UART model: shifts each byte for a while, then pulses done for one cycle.
        initial begin
            done_l = 1'b0;
            forever begin
                @(negedge clk iff tx_wr[g] === 1'b1);
                while (withhold[g]) @(posedge clk);
                repeat (rand_delay[g] ? $urandom_range(50, 1) : uart_delay[g]) @(posedge clk);
                #1 done_l = 1'b1;
                @(posedge clk);
                #1 done_l = 1'b0;
            end
        end
    end

    function automatic void exp_push(int g, logic [7:0] d);
        if (g == 0) exp_q0.push_back(d); else exp_q1.push_back(d);
        accepted[g]++;
    endfunction

    function automatic int exp_size(int g);
        return (g == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [7:0] exp_pop(int g);
        return (g == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares every transmitted byte against the oldest accepted byte.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst_n[g] === 1'b1) begin
                if (in_done[g]) done_cnt[g]++;
                if (32'(level[g]) > max_level[g]) max_level[g] = 32'(level[g]);
                if (tx_wr[g]) begin
                    txwr_cnt[g]++;
                    checks++;
                    if (exp_size(g) == 0) begin
                        errors++;
                        $display("FAIL tx_unexpected[%0d]: got tx_wr with %02h, expected no byte", g, tx_data[g]);
                    end else begin
                        logic [7:0] e;
                        e = exp_pop(g);
                        if (tx_data[g] !== e) begin
                            errors++;
                            $display("FAIL tx_order[%0d]: got %02h, expected %02h", g, tx_data[g], e);
                        end
                    end
                end
            end
        end
    end

    task automatic pulse_wr(int g, logic [7:0] d);
        @(posedge clk);
        #1 in_data[g] = d;
        in_wr[g] = 1'b1;
        @(posedge clk);
        #1 in_wr[g] = 1'b0;
    endtask

    task automatic wait_done(int g, int bound, string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (in_done[g]) begin
                found = 1'b1;
                break;
            end
        end
        chk(name, 32'(found), 32'd1);
    endtask

    task automatic wait_drain(int g, int bound, string name);
        int n;
        n = 0;
        while (exp_size(g) != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(exp_size(g)), 32'd0);
        repeat (200) @(negedge clk);
        chk({name, "_empty"}, 32'(empty[g]), 32'd1);
        chk({name, "_done_count"}, done_cnt[g], accepted[g]);
    endtask

    task automatic chk_reset_outputs(int g, string name);
        chk({name, "_level"},    32'(level[g]),    32'd0);
        chk({name, "_empty"},    32'(empty[g]),    32'd1);
        chk({name, "_full"},     32'(full[g]),     32'd0);
        chk({name, "_in_done"},  32'(in_done[g]),  32'd0);
        chk({name, "_tx_wr"},    32'(tx_wr[g]),    32'd0);
        chk({name, "_tx_data"},  32'(tx_data[g]),  32'd0);
        chk({name, "_overflow"}, 32'(overflow[g]), 32'd0);
    endtask

    initial begin
        #900000;
        errors++;
        $display("FAIL watchdog: simulation still running, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [7:0] burst [6];
        int unsigned base;
        int seen;

        for (int g = 0; g < 2; g++) begin
            rst_n[g] = 1'b0; in_data[g] = '0; in_wr[g] = 1'b0; ovf_clr[g] = 1'b0;
            withhold[g] = 1'b0; rand_delay[g] = 1'b0;
            done_cnt[g] = 0; txwr_cnt[g] = 0; accepted[g] = 0; max_level[g] = 0;
        end
        uart_delay[0] = 3;
        uart_delay[1] = 5;

        repeat (3) @(negedge clk);
        chk_reset_outputs(0, "reset_d4");
        chk_reset_outputs(1, "reset_d2");
        @(posedge clk);
        #1 rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // Single byte through the deep FIFO.
        exp_push(0, 8'h81);
        pulse_wr(0, 8'h81);
        @(negedge clk);
        chk("single_in_done", 32'(in_done[0]), 32'd1);
        chk("single_level1",  32'(level[0]),   32'd1);
        @(negedge clk);
        chk("single_tx_wr",   32'(tx_wr[0]),   32'd1);
        chk("single_tx_data", 32'(tx_data[0]), 32'h81);
        chk("single_level0",  32'(level[0]),   32'd0);
        chk("single_done_gone", 32'(in_done[0]), 32'd0);
        repeat (10) @(negedge clk);
        chk("single_idle_tx_wr", 32'(tx_wr[0]), 32'd0);
        chk("single_idle_empty", 32'(empty[0]), 32'd1);

        // S3G reply burst against a slow UART.
        uart_delay[0] = 160;
        burst = '{8'hD5, 8'h03, 8'h81, 8'hBA, 8'hCE, 8'h00};
        burst[5] = 8'($urandom);
        max_level[0] = 0;
        for (int i = 0; i < 6; i++) begin
            exp_push(0, burst[i]);
            pulse_wr(0, burst[i]);
            wait_done(0, 1, "burst_in_done");
        end
        wait_drain(0, 1300, "burst_drain");
        chk("burst_peak_level", max_level[0], 32'd5);

        // Fill the shallow FIFO with the UART stalled.
        withhold[1] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            exp_push(1, 8'(i));
            pulse_wr(1, 8'(i));
            wait_done(1, 1, "fill_in_done");
        end
        chk("fill_full",  32'(full[1]),  32'd1);
        chk("fill_level", 32'(level[1]), 32'd4);
        exp_push(1, 8'h06);
        pulse_wr(1, 8'h06);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (in_done[1]) seen++;
        end
        chk("held_no_in_done", 32'(seen), 32'd0);
        chk("held_level", 32'(level[1]), 32'd4);

        // Overflow while a byte is held.
        pulse_wr(1, 8'hEE);
        @(negedge clk);
        chk("ovf_set", 32'(overflow[1]), 32'd1);
        chk("ovf_drop_no_done", 32'(in_done[1]), 32'd0);
        @(posedge clk);
        #1 ovf_clr[1] = 1'b1;
        @(posedge clk);
        #1 ovf_clr[1] = 1'b0;
        @(negedge clk);
        chk("ovf_clear", 32'(overflow[1]), 32'd0);
        @(posedge clk);
        #1 ovf_clr[1] = 1'b1;
        in_data[1] = 8'hEE;
        in_wr[1] = 1'b1;
        @(posedge clk);
        #1 ovf_clr[1] = 1'b0;
        in_wr[1] = 1'b0;
        @(negedge clk);
        chk("ovf_set_wins", 32'(overflow[1]), 32'd1);
        @(posedge clk);
        #1 ovf_clr[1] = 1'b1;
        @(posedge clk);
        #1 ovf_clr[1] = 1'b0;

        withhold[1] = 1'b0;
        wait_done(1, 40, "commit_in_done");
        wait_drain(1, 300, "fill_drain");
        chk("fill_ovf_cleared", 32'(overflow[1]), 32'd0);

        // Pointer wrap with random UART pacing.
        rand_delay[1] = 1'b1;
        max_level[1] = 0;
        for (int i = 0; i < 20; i++) begin
            exp_push(1, 8'(8'h10 + i));
            pulse_wr(1, 8'(8'h10 + i));
            wait_done(1, 200, "wrap_in_done");
        end
        wait_drain(1, 1500, "wrap_drain");
        rand_delay[1] = 1'b0;
        chk("wrap_no_overflow", 32'(overflow[1]), 32'd0);
        chk("wrap_level_bound", 32'(max_level[1] <= 4), 32'd1);

        // Async reset while the drain FSM waits, three bytes queued.
        uart_delay[1] = 30;
        for (int i = 0; i < 4; i++) begin
            exp_push(1, 8'(8'hA0 + i));
            pulse_wr(1, 8'(8'hA0 + i));
            wait_done(1, 1, "rst_pre_in_done");
        end
        chk("rst_pre_level", 32'(level[1]), 32'd3);
        @(posedge clk);
        #2 rst_n[1] = 1'b0;
        #1 chk_reset_outputs(1, "async_reset");
        exp_q1.delete();
        repeat (2) @(posedge clk);
        #1 rst_n[1] = 1'b1;
        base = txwr_cnt[1];
        repeat (40) @(negedge clk);
        chk("stale_done_no_tx_wr", txwr_cnt[1], base);
        exp_push(1, 8'h42);
        pulse_wr(1, 8'h42);
        wait_done(1, 1, "post_reset_in_done");
        wait_drain(1, 300, "post_reset_drain");
        chk("post_reset_tx_count", txwr_cnt[1], base + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
